// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register and ALU operand select with EX/MEM and MEM/WB forwarding.
// Build option: define OPERAND_FWD_EN to enable forwarding and stall-time operand refresh.
module ex_operand_stage #(
  parameter int XLEN = 64,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_pc,
  input  logic [RA_W-1:0] id_rs1_addr,
  input  logic [RA_W-1:0] id_rs2_addr,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_alu_src,
  input  logic            id_op1_pc,
  input  logic [3:0]      id_alu_ctrl,
  input  logic [RA_W-1:0] id_rd_addr,
  input  logic            id_reg_write,
  input  logic            flush,
  input  logic            ex_ready,
  input  logic            exmem_reg_write,
  input  logic [RA_W-1:0] exmem_rd_addr,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [RA_W-1:0] memwb_rd_addr,
  input  logic [XLEN-1:0] memwb_result,
  output logic            ex_valid,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [3:0]      alu_sel,
  output logic [XLEN-1:0] ex_store_data,
  output logic [XLEN-1:0] ex_pc,
  output logic [RA_W-1:0] ex_rd_addr,
  output logic            ex_reg_write
);

  // Handshake: a transfer from ID happens on a rising edge where id_valid && id_ready;
  // the held instruction leaves on an edge where ex_valid && ex_ready. id_ready never
  // looks at id_valid, and flush cancels both the held and any incoming instruction.

  logic            valid_q;
  logic [XLEN-1:0] pc_q, rs1_data_q, rs2_data_q, imm_q;
  logic [RA_W-1:0] rs1_addr_q, rs2_addr_q, rd_addr_q;
  logic            alu_src_q, op1_pc_q, reg_write_q;
  logic [3:0]      alu_ctrl_q;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;
  logic            accept;

  assign id_ready = ~valid_q | ex_ready;
  assign accept   = id_valid & id_ready & ~flush;

`ifdef OPERAND_FWD_EN
  logic stall;
  assign stall = valid_q & ~ex_ready;

  // EX/MEM is younger than MEM/WB, so it wins; x0 is never forwarded.
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (rs1_addr_q != '0) begin
      if (exmem_reg_write && exmem_rd_addr == rs1_addr_q)      fwd_rs1 = exmem_result;
      else if (memwb_reg_write && memwb_rd_addr == rs1_addr_q) fwd_rs1 = memwb_result;
    end
    fwd_rs2 = rs2_data_q;
    if (rs2_addr_q != '0) begin
      if (exmem_reg_write && exmem_rd_addr == rs2_addr_q)      fwd_rs2 = exmem_result;
      else if (memwb_reg_write && memwb_rd_addr == rs2_addr_q) fwd_rs2 = memwb_result;
    end
  end
`else
  logic unused_fwd;
  assign fwd_rs1    = rs1_data_q;
  assign fwd_rs2    = rs2_data_q;
  assign unused_fwd = ^{exmem_reg_write, exmem_rd_addr, exmem_result,
                        memwb_reg_write, memwb_rd_addr, memwb_result,
                        rs1_addr_q, rs2_addr_q};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      alu_src_q   <= 1'b0;
      op1_pc_q    <= 1'b0;
      alu_ctrl_q  <= 4'b0000;
      rd_addr_q   <= '0;
      reg_write_q <= 1'b0;
    end else begin
      if (flush)         valid_q <= 1'b0;
      else if (accept)   valid_q <= 1'b1;
      else if (ex_ready) valid_q <= 1'b0;

      if (accept) begin
        pc_q        <= id_pc;
        rs1_addr_q  <= id_rs1_addr;
        rs2_addr_q  <= id_rs2_addr;
        rs1_data_q  <= id_rs1_data;
        rs2_data_q  <= id_rs2_data;
        imm_q       <= id_imm;
        alu_src_q   <= id_alu_src;
        op1_pc_q    <= id_op1_pc;
        alu_ctrl_q  <= id_alu_ctrl;
        rd_addr_q   <= id_rd_addr;
        reg_write_q <= id_reg_write;
      end
`ifdef OPERAND_FWD_EN
      // Latch forwarded values while stalled so a producer retiring past WB is kept.
      else if (stall && !flush) begin
        rs1_data_q <= fwd_rs1;
        rs2_data_q <= fwd_rs2;
      end
`endif
    end
  end

  assign ex_valid      = valid_q;
  assign op1           = op1_pc_q ? pc_q : fwd_rs1;
  assign op2           = alu_src_q ? imm_q : fwd_rs2;
  assign alu_sel       = alu_ctrl_q;
  assign ex_store_data = fwd_rs2;
  assign ex_pc         = pc_q;
  assign ex_rd_addr    = rd_addr_q;
  assign ex_reg_write  = reg_write_q & valid_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed steps then random traffic vs a reference model.
// Expectations follow OPERAND_FWD_EN the same way the design build does.
module tb_ex_operand_stage;
  localparam int XLEN = 64;
  localparam int RA_W = 5;
`ifdef OPERAND_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid, id_ready;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [RA_W-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic            id_alu_src, id_op1_pc, id_reg_write;
  logic [3:0]      id_alu_ctrl;
  logic            flush, ex_ready;
  logic            exmem_reg_write, memwb_reg_write;
  logic [RA_W-1:0] exmem_rd_addr, memwb_rd_addr;
  logic [XLEN-1:0] exmem_result, memwb_result;
  logic            ex_valid, ex_reg_write;
  logic [XLEN-1:0] op1, op2, ex_store_data, ex_pc;
  logic [3:0]      alu_sel;
  logic [RA_W-1:0] ex_rd_addr;

  int n_cmp  = 0;
  int n_fail = 0;

  ex_operand_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_op1_pc(id_op1_pc), .id_alu_ctrl(id_alu_ctrl),
    .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
    .flush(flush), .ex_ready(ex_ready),
    .exmem_reg_write(exmem_reg_write), .exmem_rd_addr(exmem_rd_addr), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd_addr(memwb_rd_addr), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .op1(op1), .op2(op2), .alu_sel(alu_sel),
    .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write)
  );

  // clock
  always #5 clk = ~clk;

  // reference model: the instruction currently sitting in EX
  bit             m_valid;
  logic [XLEN-1:0] m_pc, m_rs1d, m_rs2d, m_imm;
  logic [RA_W-1:0] m_rs1a, m_rs2a, m_rd;
  logic            m_src, m_op1pc, m_rw;
  logic [3:0]      m_ctrl;

  function automatic logic [XLEN-1:0] model_src(input logic [RA_W-1:0] rs, input logic [XLEN-1:0] stored);
    if (!FWD || rs == 0) return stored;
    if (exmem_reg_write && exmem_rd_addr == rs) return exmem_result;
    if (memwb_reg_write && memwb_rd_addr == rs) return memwb_result;
    return stored;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [XLEN-1:0] s1, s2;
    s1 = model_src(m_rs1a, m_rs1d);
    s2 = model_src(m_rs2a, m_rs2d);
    chk("id_ready", id_ready, (!m_valid || ex_ready));
    chk("ex_valid", ex_valid, m_valid);
    chk("ex_reg_write", ex_reg_write, m_valid && m_rw);
    if (m_valid) begin
      chk("op1", op1, m_op1pc ? m_pc : s1);
      chk("op2", op2, m_src ? m_imm : s2);
      chk("alu_sel", alu_sel, m_ctrl);
      chk("store_data", ex_store_data, s2);
      chk("ex_pc", ex_pc, m_pc);
      chk("rd_addr", ex_rd_addr, m_rd);
    end
  endtask

  // one clock: update the model from the inputs seen at the edge, then check
  task automatic tick();
    logic [XLEN-1:0] s1, s2;
    @(posedge clk);
    s1 = model_src(m_rs1a, m_rs1d);
    s2 = model_src(m_rs2a, m_rs2d);
    if (rst) begin
      m_valid = 0; m_pc = 0; m_rs1d = 0; m_rs2d = 0; m_imm = 0; m_rs1a = 0; m_rs2a = 0;
      m_rd = 0; m_src = 0; m_op1pc = 0; m_rw = 0; m_ctrl = 0;
    end else if (flush) begin
      m_valid = 0;
    end else if (id_valid && (!m_valid || ex_ready)) begin
      m_valid = 1; m_pc = id_pc; m_rs1a = id_rs1_addr; m_rs2a = id_rs2_addr;
      m_rs1d = id_rs1_data; m_rs2d = id_rs2_data; m_imm = id_imm; m_src = id_alu_src;
      m_op1pc = id_op1_pc; m_ctrl = id_alu_ctrl; m_rd = id_rd_addr; m_rw = id_reg_write;
    end else if (m_valid && ex_ready) begin
      m_valid = 0;
    end else if (m_valid) begin
      m_rs1d = s1;
      m_rs2d = s2;
    end
    #1;
    check_outputs();
  endtask

  // driver
  task automatic offer(input logic [XLEN-1:0] pc, input logic [RA_W-1:0] rs1a, input logic [XLEN-1:0] rs1d,
                       input logic [RA_W-1:0] rs2a, input logic [XLEN-1:0] rs2d, input logic [XLEN-1:0] imm,
                       input logic src, input logic op1pc, input logic [3:0] ctrl,
                       input logic [RA_W-1:0] rd, input logic rw);
    id_valid = 1; id_pc = pc; id_rs1_addr = rs1a; id_rs1_data = rs1d; id_rs2_addr = rs2a;
    id_rs2_data = rs2d; id_imm = imm; id_alu_src = src; id_op1_pc = op1pc; id_alu_ctrl = ctrl;
    id_rd_addr = rd; id_reg_write = rw;
  endtask

  task automatic no_fwd();
    exmem_reg_write = 0; exmem_rd_addr = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd_addr = 0; memwb_result = 0;
  endtask

  initial begin
    rst = 1; flush = 0; ex_ready = 1; no_fwd();
    m_valid = 0;
    offer(64'h123, 5'd1, 64'h9, 5'd2, 64'h8, 64'h7, 1'b0, 1'b0, 4'b0010, 5'd4, 1'b1);

    // reset held two cycles with id_valid high
    tick(); tick();
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_op1", op1, 0);
    chk("rst_op2", op2, 0);
    chk("rst_alu_sel", alu_sel, 0);
    chk("rst_reg_write", ex_reg_write, 0);
    rst = 0; id_valid = 0;
    tick();
    chk("post_rst_id_ready", id_ready, 1);

    // plain ADD
    offer(64'h100, 5'd1, 64'd5, 5'd2, 64'd7, 64'h0, 1'b0, 1'b0, 4'b0010, 5'd6, 1'b1);
    tick();
    chk("add_op1", op1, 64'd5);
    chk("add_op2", op2, 64'd7);
    chk("add_alu_sel", alu_sel, 4'b0010);
    chk("add_valid", ex_valid, 1);

    // forwarding priority, combinational on the held instruction
    offer(64'h104, 5'd3, 64'h11, 5'd4, 64'h22, 64'h0, 1'b0, 1'b0, 4'b0000, 5'd7, 1'b1);
    tick();
    id_valid = 0; ex_ready = 0;
    exmem_reg_write = 1; exmem_rd_addr = 5'd3; exmem_result = 64'hAA;
    memwb_reg_write = 1; memwb_rd_addr = 5'd3; memwb_result = 64'hBB;
    #1;
    chk("fwd_exmem", op1, FWD ? 64'hAA : 64'h11);
    check_outputs();
    exmem_reg_write = 0;
    #1;
    chk("fwd_memwb", op1, FWD ? 64'hBB : 64'h11);
    ex_ready = 1; exmem_reg_write = 1;
    exmem_rd_addr = 5'd0; memwb_rd_addr = 5'd0;
    offer(64'h108, 5'd0, 64'h0, 5'd0, 64'h0, 64'h0, 1'b0, 1'b0, 4'b0001, 5'd8, 1'b0);
    tick();
    chk("fwd_x0", op1, 64'h0);

    // stall-time capture from MEM/WB
    no_fwd();
    offer(64'h40, 5'd1, 64'h1, 5'd2, 64'h55, 64'h0, 1'b0, 1'b0, 4'b0110, 5'd9, 1'b1);
    tick();
    offer(64'h80, 5'd1, 64'h2, 5'd1, 64'h3, 64'h0, 1'b0, 1'b0, 4'b0010, 5'd5, 1'b1);
    ex_ready = 0;
    memwb_reg_write = 1; memwb_rd_addr = 5'd2; memwb_result = 64'h1234;
    #1;
    chk("stall_id_ready", id_ready, 0);
    tick();
    memwb_reg_write = 0;
    tick();
    chk("stall_pc_held", ex_pc, 64'h40);
    chk("stall_store", ex_store_data, FWD ? 64'h1234 : 64'h55);
    ex_ready = 1;
    #1;
    chk("stall_release_store", ex_store_data, FWD ? 64'h1234 : 64'h55);
    tick();

    // flush with a new instruction offered and EX stalled
    ex_ready = 0; flush = 1;
    tick();
    chk("flush_valid", ex_valid, 0);
    chk("flush_reg_write", ex_reg_write, 0);
    chk("flush_id_ready", id_ready, 1);
    flush = 0;

    // AUIPC-style operands
    ex_ready = 1;
    offer(64'h1000, 5'd1, 64'hDEAD, 5'd2, 64'hBEEF, 64'h2000, 1'b1, 1'b1, 4'b0010, 5'd10, 1'b1);
    tick();
    chk("auipc_op1", op1, 64'h1000);
    chk("auipc_op2", op2, 64'h2000);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 60) == 0);
      flush = ($urandom_range(0, 15) == 0);
      ex_ready = ($urandom_range(0, 2) != 0);
      offer({$urandom, $urandom}, 5'($urandom_range(0, 3)), {$urandom, $urandom},
            5'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
            1'($urandom), 1'($urandom), 4'($urandom), 5'($urandom), 1'($urandom));
      id_valid = 1'($urandom);
      exmem_reg_write = 1'($urandom); exmem_rd_addr = 5'($urandom_range(0, 3));
      exmem_result = {$urandom, $urandom};
      memwb_reg_write = 1'($urandom); memwb_rd_addr = 5'($urandom_range(0, 3));
      memwb_result = {$urandom, $urandom};
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
ID/EX pipeline register and operand-select stage that sits directly upstream of the 64-bit ALU. It captures decoded instruction fields from ID and resolves RAW hazards by forwarding from EX/MEM and MEM/WB. It then drives op1, op2 and the 4-bit alu_sel straight into the ALU. Flow control is a valid/ready handshake; a flush input squashes the held instruction.

Parameters:
XLEN, 64, datapath width
RA_W, 5, register address width

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
id_valid  in  1  ID presents an instruction
id_ready  out  1  stage can accept
id_pc  in  XLEN  instruction PC
id_rs1_addr  in  RA_W  source 1 index
id_rs2_addr  in  RA_W  source 2 index
id_rs1_data  in  XLEN  regfile read 1
id_rs2_data  in  XLEN  regfile read 2
id_imm  in  XLEN  sign-extended immediate
id_alu_src  in  1  0: op2=rs2, 1: op2=imm
id_op1_pc  in  1  1: op1=pc (auipc/jal)
id_alu_ctrl  in  4  ALU function code
id_rd_addr  in  RA_W  destination index
id_reg_write  in  1  writes rd
flush  in  1  squash held/incoming instruction
ex_ready  in  1  downstream accepts
exmem_reg_write  in  1  EX/MEM writes rd
exmem_rd_addr  in  RA_W  EX/MEM rd
exmem_result  in  XLEN  EX/MEM value
memwb_reg_write  in  1  MEM/WB writes rd
memwb_rd_addr  in  RA_W  MEM/WB rd
memwb_result  in  XLEN  MEM/WB value
ex_valid  out  1  instruction in EX
op1  out  XLEN  ALU operand 1
op2  out  XLEN  ALU operand 2
alu_sel  out  4  ALU function code
ex_store_data  out  XLEN  forwarded rs2 value (store data)
ex_pc  out  XLEN  PC of held instruction
ex_rd_addr  out  RA_W  destination index
ex_reg_write  out  1  reg_write_q AND ex_valid

Behaviour:
- Reset: ex_valid=0. All registered payload (pc, rs addr/data, imm, ctrl, rd, reg_write) = 0. Therefore op1=op2=ex_store_data=ex_pc=0, alu_sel=4'b0000, ex_rd_addr=0, ex_reg_write=0.
- id_ready = !ex_valid | ex_ready (combinational). Does not depend on id_valid.
- Accept when id_valid & id_ready & !flush. At the next edge, payload is loaded and ex_valid=1. Latency ID->ALU operands is 1 cycle.
- Drain with no new instruction: ex_valid & ex_ready & !id_valid gives ex_valid=0 next edge.
- Stall: ex_valid & !ex_ready holds the payload unchanged. Exception: the stored rs1/rs2 data is overwritten each cycle with its forwarded value, so a producer retiring past MEM/WB during the stall is not lost.
- Flush: next edge ex_valid=0, whatever the state of ex_ready and id_valid. Flush wins over a simultaneous accept. rst wins over flush.
- Forwarding (per source, combinational on the registered address):
  - EX/MEM match (reg_write & rd==rs & rd!=0) has top priority.
  - A MEM/WB match is used next.
  - Otherwise the stored regfile data is used.
  - x0 is never forwarded and always reads as its stored data, which is 0 from the regfile.
- Operand select:
  - op1 = id_op1_pc_q ? pc_q : fwd_rs1.
  - op2 = alu_src_q ? imm_q : fwd_rs2.
  - ex_store_data = fwd_rs2 always.
- alu_sel = alu_ctrl_q, passed through unmodified. Codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
- All arithmetic is in the ALU. This stage only muxes; no width changes.
- Outputs when ex_valid=0 are don't-care except ex_reg_write, which must be 0.

Optional Feature:
OPERAND_FWD_EN
- Defined: forwarding as above, plus the stall-time capture of forwarded data.
- Undefined: fwd_rs1=rs1_data_q and fwd_rs2=rs2_data_q. exmem_*/memwb_* inputs are ignored and no stall-time refresh occurs; hazards are the hazard unit's responsibility.
- Ports are identical in both builds.

Test Plan:
- rst=1 for 2 cycles with id_valid=1 -> ex_valid=0, op1=op2=0, alu_sel=0, ex_reg_write=0. id_ready=1 after reset.
- Accept ADD: rs1_data=5, rs2_data=7, alu_src=0, alu_ctrl=0010, no forward match -> next cycle op1=5, op2=7, alu_sel=0010, ex_valid=1.
- Forward priority: rs1_addr=3, exmem rd=3 result=0xAA, memwb rd=3 result=0xBB, both reg_write=1 -> op1=0xAA. Drop exmem_reg_write -> op1=0xBB. rs1_addr=0 with the same matches -> op1 = stored data.
- Stall capture: ex_ready=0 with memwb rd=2 result=0x1234 for 1 cycle, rs2_addr=2, then memwb_reg_write=0 -> ex_store_data stays 0x1234 when ex_ready rises. Payload held and id_ready=0 throughout the stall.
- Flush with id_valid=1 and ex_ready=0 -> next cycle ex_valid=0, ex_reg_write=0, id_ready=1.
- AUIPC: id_op1_pc=1, pc=0x1000, alu_src=1, imm=0x2000 -> op1=0x1000, op2=0x2000. With the forward macro undefined, the forward-priority case gives op1 = stored rs1_data.
